vga_pmod_capture: RTL and testbench

- Receiving end of the TinyVGA PMOD output bus the game drives on uo_out.
- Samples the 8-bit pin bus once per pixel clock and recovers pixel coordinates from the hsync/vsync edges.
- Decodes 2-bit R/G/B per active pixel, checks line and frame timing, and produces a per-frame signature.
- Used as the self-check sink in the top-level bench and as a loop-back monitor on the FPGA demo board.

---
 rtl/vga_pmod_capture.sv | 170 +++++++++++++++++
 tb/tb_vga_pmod_capture.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/vga_pmod_capture.sv
// Receiving end of the TinyVGA PMOD bus: recovers pixel coordinates and colour,
// checks line/frame timing, tracks lock and produces a per-frame signature.
module vga_pmod_capture #(
    parameter int H_TOTAL        = 800,
    parameter int H_ACTIVE_START = 144,
    parameter int H_ACTIVE       = 640,
    parameter int V_TOTAL        = 525,
    parameter int V_ACTIVE_START = 34,
    parameter int V_ACTIVE       = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_vga,
    output logic        o_pix_valid,
    output logic [9:0]  o_x,
    output logic [9:0]  o_y,
    output logic [1:0]  o_r,
    output logic [1:0]  o_g,
    output logic [1:0]  o_b,
    output logic        o_frame_done,
    output logic [15:0] o_frame_sig,
    output logic        o_locked,
    output logic        o_err_h,
    output logic        o_err_v
);

    localparam logic [9:0] CNT_MAX  = 10'd1023;
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HA_FIRST = 10'(H_ACTIVE_START);
    localparam logic [9:0] HA_LAST  = 10'(H_ACTIVE_START + H_ACTIVE - 1);
    localparam logic [9:0] VA_FIRST = 10'(V_ACTIVE_START);
    localparam logic [9:0] VA_LAST  = 10'(V_ACTIVE_START + V_ACTIVE - 1);
    localparam logic [9:0] X_LAST   = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_ACTIVE - 1);

    typedef enum logic [1:0] {
        UNSYNC  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } lock_state_t;

    function automatic logic [15:0] sig_next(input logic [15:0] sig, input logic [5:0] rgb);
        return {sig[14:0], sig[15]} ^ {10'b0, rgb};
    endfunction

    logic [7:0]  r_s1, r_s1_d;
    logic [9:0]  r_hcnt, r_vcnt;
    logic        r_vpend, r_h_seen, r_v_seen, r_clean;
    logic [15:0] r_sig;
    lock_state_t r_state, w_state_next;

    logic        w_h_edge, w_v_edge, w_vrst, w_valid, w_err_h, w_err_v, w_last;
    logic [9:0]  w_hcnt, w_vcnt;
    logic [1:0]  w_r, w_g, w_b;

    assign w_h_edge = ~r_s1[7] & r_s1_d[7];
    assign w_v_edge = ~r_s1[3] & r_s1_d[3];
    assign w_vrst   = w_h_edge & (r_vpend | w_v_edge);
    assign w_r      = {r_s1[0], r_s1[4]};
    assign w_g      = {r_s1[1], r_s1[5]};
    assign w_b      = {r_s1[2], r_s1[6]};
    assign w_err_h  = w_h_edge & r_h_seen & (r_hcnt != H_LAST);
    assign w_err_v  = w_vrst & r_v_seen & (r_vcnt != V_LAST);
    assign w_last   = o_pix_valid & (o_x == X_LAST) & (o_y == Y_LAST);

    // Sample-index counters for the sample currently held in r_s1.
    always_comb begin
        w_hcnt = r_hcnt;
        w_vcnt = r_vcnt;
        if (w_h_edge) begin
            w_hcnt = 10'd0;
        end else if (r_hcnt != CNT_MAX) begin
            w_hcnt = r_hcnt + 10'd1;
        end else begin
            w_hcnt = CNT_MAX;
        end
        if (w_vrst) begin
            w_vcnt = 10'd0;
        end else if (w_h_edge && (r_vcnt != CNT_MAX)) begin
            w_vcnt = r_vcnt + 10'd1;
        end else begin
            w_vcnt = r_vcnt;
        end
        w_valid = r_v_seen && (w_hcnt >= HA_FIRST) && (w_hcnt <= HA_LAST)
                  && (w_vcnt >= VA_FIRST) && (w_vcnt <= VA_LAST);
    end

    // Lock tracking: an error always falls back to ACQUIRE, a clean frame locks.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            UNSYNC: begin
                if (w_vrst) w_state_next = ACQUIRE;
                else        w_state_next = UNSYNC;
            end
            ACQUIRE: begin
                if (w_err_h || w_err_v)       w_state_next = ACQUIRE;
                else if (w_vrst && r_clean)   w_state_next = LOCKED;
                else                          w_state_next = ACQUIRE;
            end
            LOCKED: begin
                if (w_err_h || w_err_v) w_state_next = ACQUIRE;
                else                    w_state_next = LOCKED;
            end
            default: w_state_next = UNSYNC;
        endcase
    end

    // Input sampling, counters and sync/frame bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1     <= 8'd0;
            r_s1_d   <= 8'd0;
            r_hcnt   <= 10'd0;
            r_vcnt   <= 10'd0;
            r_vpend  <= 1'b0;
            r_h_seen <= 1'b0;
            r_v_seen <= 1'b0;
            r_clean  <= 1'b0;
            r_sig    <= 16'd0;
            r_state  <= UNSYNC;
        end else begin
            r_s1     <= i_vga;
            r_s1_d   <= r_s1;
            r_hcnt   <= w_hcnt;
            r_vcnt   <= w_vcnt;
            r_h_seen <= r_h_seen | w_h_edge;
            r_v_seen <= r_v_seen | w_vrst;
            r_state  <= w_state_next;
            if (w_h_edge)      r_vpend <= 1'b0;
            else if (w_v_edge) r_vpend <= 1'b1;
            // A new frame starts a fresh clean check even if the old one ended badly.
            if (w_vrst)                  r_clean <= 1'b1;
            else if (w_err_h || w_err_v) r_clean <= 1'b0;
            if (w_vrst)       r_sig <= 16'd0;
            else if (w_valid) r_sig <= sig_next(r_sig, {w_r, w_g, w_b});
        end
    end

    // Registered outputs, two cycles behind the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_pix_valid  <= 1'b0;
            o_x          <= 10'd0;
            o_y          <= 10'd0;
            o_r          <= 2'd0;
            o_g          <= 2'd0;
            o_b          <= 2'd0;
            o_frame_done <= 1'b0;
            o_frame_sig  <= 16'd0;
            o_locked     <= 1'b0;
            o_err_h      <= 1'b0;
            o_err_v      <= 1'b0;
        end else begin
            o_pix_valid  <= w_valid;
            o_x          <= w_valid ? (w_hcnt - HA_FIRST) : 10'd0;
            o_y          <= w_valid ? (w_vcnt - VA_FIRST) : 10'd0;
            o_r          <= w_valid ? w_r : 2'd0;
            o_g          <= w_valid ? w_g : 2'd0;
            o_b          <= w_valid ? w_b : 2'd0;
            o_frame_done <= w_last;
            o_frame_sig  <= w_last ? r_sig : o_frame_sig;
            o_locked     <= (w_state_next == LOCKED);
            o_err_h      <= w_err_h;
            o_err_v      <= w_err_v;
        end
    end

endmodule

// File: tb/tb_vga_pmod_capture.sv
// Directed bench for vga_pmod_capture using a reduced 20x12 timing so that
// many complete frames fit in a short run.
module tb_vga_pmod_capture;

    localparam int HT = 20, HAS = 4, HA = 8, VT = 12, VAS = 3, VA = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  i_vga;
    logic        o_pix_valid, o_frame_done, o_locked, o_err_h, o_err_v;
    logic [9:0]  o_x, o_y;
    logic [1:0]  o_r, o_g, o_b;
    logic [15:0] o_frame_sig;

    vga_pmod_capture #(
        .H_TOTAL(HT), .H_ACTIVE_START(HAS), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_ACTIVE_START(VAS), .V_ACTIVE(VA)
    ) dut (
        .clk(clk), .rst(rst), .i_vga(i_vga),
        .o_pix_valid(o_pix_valid), .o_x(o_x), .o_y(o_y),
        .o_r(o_r), .o_g(o_g), .o_b(o_b),
        .o_frame_done(o_frame_done), .o_frame_sig(o_frame_sig),
        .o_locked(o_locked), .o_err_h(o_err_h), .o_err_v(o_err_v)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       known;
        logic       v;
        logic [9:0] x;
        logic [9:0] y;
        logic [5:0] col;
        logic       eh;
        logic       ev;
        logic       done;
    } exp_t;

    exp_t        p0, p1;
    int          n_checks = 0;
    int          n_fail = 0;
    logic        vseen_m;
    logic [15:0] sig_m, sig_final_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] pix_col(input int mode, input int x, input int y);
        case (mode)
            0:       return {x[1:0], 4'b0000};
            2:       return (x == 0 && y == 0) ? 6'b111111 : 6'b000000;
            3:       return 6'b11_10_01;
            default: return 6'b000000;
        endcase
    endfunction

    // One pixel clock: check outputs for the sample driven two cycles ago, drive the next.
    task automatic step(input logic hs, input logic vs, input logic [5:0] col, input exp_t e);
        @(posedge clk);
        #1;
        if (p1.known) begin
            chk("pix_valid", o_pix_valid, p1.v);
            chk("x", o_x, p1.x);
            chk("y", o_y, p1.y);
            chk("colour", {o_r, o_g, o_b}, p1.col);
            chk("err_h", o_err_h, p1.eh);
            chk("err_v", o_err_v, p1.ev);
            chk("frame_done", o_frame_done, p1.done);
        end
        p1 = p0;
        p0 = e;
        i_vga = {hs, col[0], col[2], col[4], vs, col[1], col[3], col[5]};
    endtask

    task automatic run_line(input int vc, input int len, input int mode, input logic eh, input logic ev);
        for (int hc = 0; hc < len; hc++) begin
            logic       act, valid, done;
            logic [5:0] col;
            exp_t       e;
            if (hc == 0 && vc == 0) begin
                vseen_m = 1'b1;
                sig_m   = 16'h0000;
            end
            act   = (hc >= HAS) && (hc < HAS + HA) && (vc >= VAS) && (vc < VAS + VA);
            valid = vseen_m && act;
            col   = (act || mode == 3) ? pix_col(mode, hc - HAS, vc - VAS) : 6'b000000;
            done  = vseen_m && (hc == HAS + HA) && (vc == VAS + VA - 1);
            if (valid) sig_m = {sig_m[14:0], sig_m[15]} ^ {10'b0, col};
            if (done) sig_final_m = sig_m;
            e       = '0;
            e.known = 1'b1;
            e.v     = valid;
            e.x     = valid ? 10'(hc - HAS) : 10'd0;
            e.y     = valid ? 10'(vc - VAS) : 10'd0;
            e.col   = valid ? col : 6'b000000;
            e.eh    = (hc == 0) && eh;
            e.ev    = (hc == 0) && ev;
            e.done  = done;
            step(hc >= 2, vc >= 2, col, e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_async_a", {o_pix_valid, o_x, o_y, o_r, o_g, o_b}, 64'd0);
        chk("rst_async_b", {o_frame_done, o_frame_sig, o_locked, o_err_h, o_err_v}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold", {o_pix_valid, o_x, o_y, o_locked, o_frame_sig}, 64'd0);
        rst         = 1'b0;
        p0          = '0;
        p1          = '0;
        vseen_m     = 1'b0;
        sig_m       = 16'h0000;
        sig_final_m = 16'h0000;
    endtask

    task automatic run_frame(input int nlines, input int mode, input int short_line,
                             input int eh_line, input logic ev_start,
                             input int stall_after, input int rst_line);
        exp_t z;
        z       = '0;
        z.known = 1'b1;
        for (int vc = 0; vc < nlines; vc++) begin
            if (vc == rst_line) do_reset();
            run_line(vc, (vc == short_line) ? HT - 1 : HT, mode, vc == eh_line, (vc == 0) && ev_start);
            if (vc == stall_after) begin
                for (int i = 0; i < 1100; i++) step(1'b1, 1'b1, 6'b000000, z);
            end
        end
    endtask

    task automatic end_frame(input string tag, input logic exp_lock);
        chk({tag, "_locked"}, o_locked, exp_lock);
        chk({tag, "_sig"}, o_frame_sig, sig_final_m);
    endtask

    initial begin
        exp_t z;
        z           = '0;
        z.known     = 1'b1;
        p0          = '0;
        p1          = '0;
        vseen_m     = 1'b0;
        sig_m       = 16'h0000;
        sig_final_m = 16'h0000;
        rst         = 1'b1;
        i_vga       = 8'b1000_1000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_a", {o_pix_valid, o_x, o_y, o_r, o_g, o_b}, 64'd0);
        chk("reset_b", {o_frame_done, o_frame_sig, o_locked, o_err_h, o_err_v}, 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 6'b000000, z);

        run_frame(VT, 0, -1, -1, 1'b0, -1, -1);  end_frame("f1_clean", 1'b0);
        run_frame(VT, 0, -1, -1, 1'b0, -1, -1);  end_frame("f2_clean", 1'b1);
        run_frame(VT, 3, -1, -1, 1'b0, -1, -1);  end_frame("f3_bus", 1'b1);
        run_frame(VT, 2, -1, -1, 1'b0, -1, -1);  end_frame("f4_dot", 1'b1);
        chk("f4_sig_const", o_frame_sig, 16'h1F80);
        run_frame(VT, 1, -1, -1, 1'b0, -1, -1);  end_frame("f5_black", 1'b1);
        chk("f5_sig_zero", o_frame_sig, 16'h0000);
        run_frame(VT, 0, 3, 4, 1'b0, -1, -1);    end_frame("f6_short_line", 1'b0);
        run_frame(VT, 0, -1, -1, 1'b0, -1, -1);  end_frame("f7_reacquire", 1'b0);
        run_frame(VT, 0, -1, -1, 1'b0, -1, -1);  end_frame("f8_relock", 1'b1);
        run_frame(VT - 1, 0, -1, -1, 1'b0, -1, -1); end_frame("f9_short_frame", 1'b1);
        run_frame(VT, 0, -1, 5, 1'b1, 4, -1);    end_frame("f10_err_v_stall", 1'b0);
        run_frame(VT, 0, -1, -1, 1'b0, -1, 6);   end_frame("f11_reset_mid", 1'b0);
        run_frame(VT, 0, -1, -1, 1'b0, -1, -1);  end_frame("f12_after_rst", 1'b0);
        run_frame(VT, 0, -1, -1, 1'b0, -1, -1);  end_frame("f13_after_rst", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
